adder_sum_accumulator: RTL and testbench



---
 rtl/adder_sum_accumulator.sv | 79 +++++++
 tb/tb_adder_sum_accumulator.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_sum_accumulator.sv
// Accumulates BLOCK_LEN adder sums into a wide block total and presents each
// completed block on a double-buffered valid/ready output; flush closes a partial block.
module adder_sum_accumulator #(
  parameter int ADDER_WIDTH = 125,
  parameter int BLOCK_LEN   = 16,
  parameter int ACC_WIDTH   = 130,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDER_WIDTH:0]   sum_in,
  input  logic                   sum_valid,
  output logic                   sum_ready,
  input  logic                   flush,
  output logic [ACC_WIDTH-1:0]   acc_out,
  output logic [CNT_WIDTH-1:0]   out_count,
  output logic                   out_ovf,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(BLOCK_LEN - 1);

  logic [ACC_WIDTH-1:0] acc;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 ovf_run;

  logic                 at_last;
  logic                 in_fire;
  logic                 out_fire;
  logic                 complete;
  logic                 carry;
  logic [ACC_WIDTH:0]   sum_wide;
  logic [ACC_WIDTH-1:0] nxt;

  // Ready depends only on registers: stall just when the next sum would
  // finish a block while the previous result is still waiting for the sink.
  assign at_last   = (cnt == LAST);
  assign sum_ready = ~(out_valid & at_last);
  assign in_fire   = sum_valid & sum_ready;
  assign out_fire  = out_valid & out_ready;

  assign sum_wide = {1'b0, acc} + {{(ACC_WIDTH - ADDER_WIDTH){1'b0}}, sum_in};
  assign nxt      = sum_wide[ACC_WIDTH-1:0];
  assign carry    = in_fire & sum_wide[ACC_WIDTH];

  assign complete = (in_fire & at_last) |
                    (flush & ((cnt != '0) | in_fire) & ~out_valid);

  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      cnt       <= '0;
      ovf_run   <= 1'b0;
      acc_out   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
    end else if (complete) begin
      acc_out   <= in_fire ? nxt : acc;
      out_count <= in_fire ? cnt + 1'b1 : cnt;
      out_ovf   <= ovf_run | carry;
      out_valid <= 1'b1;
      acc       <= '0;
      cnt       <= '0;
      ovf_run   <= 1'b0;
    end else begin
      if (in_fire) begin
        acc     <= nxt;
        cnt     <= cnt + 1'b1;
        ovf_run <= ovf_run | carry;
      end
      if (out_fire) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Scoreboard bench for adder_sum_accumulator: a block-level model predicts each result,
// a monitor checks two instances (130-bit and 126-bit accumulators) every cycle.
module tb_adder_sum_accumulator;

  localparam int AW = 125;
  localparam int BL = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW:0]   sum_in;
  logic          sum_valid;
  logic          flush;
  logic          out_ready;

  logic          ready_a, ready_b;
  logic [129:0]  acc_a;
  logic [125:0]  acc_b;
  logic [CW-1:0] count_a, count_b;
  logic          ovf_a, ovf_b;
  logic          valid_a, valid_b;

  adder_sum_accumulator #(.ADDER_WIDTH(AW), .BLOCK_LEN(BL), .ACC_WIDTH(130), .CNT_WIDTH(CW)) dut_a (
    .clk(clk), .reset(reset), .sum_in(sum_in), .sum_valid(sum_valid), .sum_ready(ready_a),
    .flush(flush), .acc_out(acc_a), .out_count(count_a), .out_ovf(ovf_a),
    .out_valid(valid_a), .out_ready(out_ready)
  );

  adder_sum_accumulator #(.ADDER_WIDTH(AW), .BLOCK_LEN(BL), .ACC_WIDTH(126), .CNT_WIDTH(CW)) dut_b (
    .clk(clk), .reset(reset), .sum_in(sum_in), .sum_valid(sum_valid), .sum_ready(ready_b),
    .flush(flush), .acc_out(acc_b), .out_count(count_b), .out_ovf(ovf_b),
    .out_valid(valid_b), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [159:0] total;
    int           count;
  } exp_t;

  exp_t        sb[$];
  logic [AW:0] blk[$];
  logic        pending   = 1'b0;
  logic        exp_ready = 1'b1;
  logic        exp_valid = 1'b0;
  int          checks    = 0;
  int          failures  = 0;
  exp_t        mon_e;

  task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW:0] rand_sum();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    return t[AW:0];
  endfunction

  // Block-level reference: a block is the list of accepted sums, closed by the
  // BLOCK_LEN-th sum or by a flush when no result is pending.
  task automatic model_step(input logic fire, input logic [AW:0] s, input logic f, input logic r);
    logic         done;
    logic [159:0] total;
    if (fire) blk.push_back(s);
    done = (fire && blk.size() == BL) || (f && blk.size() != 0 && !pending);
    if (done) begin
      total = '0;
      foreach (blk[i]) total += 160'(blk[i]);
      sb.push_back('{total: total, count: blk.size()});
      blk.delete();
      pending = 1'b1;
    end else if (pending && r) begin
      pending = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [AW:0] s, input logic f, input logic r);
    logic fire;
    @(negedge clk);
    reset     = 1'b0;
    sum_valid = v;
    sum_in    = s;
    flush     = f;
    out_ready = r;
    exp_ready = !(pending && blk.size() == BL - 1);
    exp_valid = pending;
    fire      = v && exp_ready;
    @(posedge clk);
    model_step(fire, s, f, r);
  endtask

  task automatic applyReset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      reset     = 1'b1;
      sum_valid = 1'b0;
      sum_in    = '0;
      flush     = 1'b0;
      out_ready = 1'b0;
      exp_ready = !(pending && blk.size() == BL - 1);
      exp_valid = pending;
      @(posedge clk);
      blk.delete();
      sb.delete();
      pending = 1'b0;
    end
  endtask

  // Monitor: handshake lines every cycle, result fields against the scoreboard head
  // whenever a result is presented, popping it when the sink takes it.
  always begin
    @(negedge clk);
    #3;
    checkOutput("sum_ready_a", 160'(ready_a), 160'(exp_ready));
    checkOutput("sum_ready_b", 160'(ready_b), 160'(exp_ready));
    checkOutput("out_valid_a", 160'(valid_a), 160'(exp_valid));
    checkOutput("out_valid_b", 160'(valid_b), 160'(exp_valid));
    if (exp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL scoreboard_empty actual=result_presented expected=no_result at %0t", $time);
      end else begin
        mon_e = sb[0];
        checkOutput("acc_out_a",   160'(acc_a),   160'(mon_e.total[129:0]));
        checkOutput("out_count_a", 160'(count_a), 160'(mon_e.count));
        checkOutput("out_ovf_a",   160'(ovf_a),   160'((mon_e.total >> 130) != 0));
        checkOutput("acc_out_b",   160'(acc_b),   160'(mon_e.total[125:0]));
        checkOutput("out_count_b", 160'(count_b), 160'(mon_e.count));
        checkOutput("out_ovf_b",   160'(ovf_b),   160'((mon_e.total >> 126) != 0));
        if (out_ready && !reset) void'(sb.pop_front());
      end
    end
  end

  initial begin
    logic [AW:0] max_sum;
    max_sum   = '1;
    reset     = 1'b1;
    sum_valid = 1'b0;
    sum_in    = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    applyReset(2);
    #1;
    checkOutput("reset_acc_out",   160'(acc_a),   160'(0));
    checkOutput("reset_out_count", 160'(count_a), 160'(0));
    checkOutput("reset_out_ovf",   160'(ovf_b),   160'(0));
    checkOutput("reset_out_valid", 160'(valid_a), 160'(0));

    $display("[TB] unit sums");
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 126'd1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)  applyStimulus(1'b0, '0, 1'b0, 1'b1);

    $display("[TB] maximum sums");
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, max_sum, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)  applyStimulus(1'b0, '0, 1'b0, 1'b1);

    $display("[TB] backpressure");
    for (int i = 0; i < 36; i++) applyStimulus(1'b1, 126'd3, 1'b0, 1'b0);
    applyStimulus(1'b1, 126'd3, 1'b0, 1'b1);
    applyStimulus(1'b1, 126'd3, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)  applyStimulus(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)  applyStimulus(1'b0, '0, 1'b0, 1'b1);

    $display("[TB] flush");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 126'd7, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 126'd4, 1'b0, 1'b1);
    applyStimulus(1'b1, 126'd4, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1);

    $display("[TB] reset mid-block");
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 126'd5, 1'b0, 1'b1);
    applyReset(1);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 126'd1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)  applyStimulus(1'b0, '0, 1'b0, 1'b1);

    $display("[TB] flush against pending result");
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 126'd9, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 126'd11, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1);

    $display("[TB] random traffic");
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        applyReset(1);
      end else begin
        applyStimulus($urandom_range(0, 9) < 7,
                      ($urandom_range(0, 3) == 0) ? max_sum : rand_sum(),
                      $urandom_range(0, 9) == 0,
                      $urandom_range(0, 9) < 6);
      end
    end

    for (int i = 0; i < 20 && (pending || sb.size() != 0); i++) applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    #4;
    checkOutput("drain_scoreboard", 160'(sb.size()), 160'(0));
    checkOutput("drain_out_valid", 160'(valid_a), 160'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
